mouse_cursor_tracker: RTL and testbench

//  Consumes decoded PS/2 mouse packets from the PS/2 mouse driver and keeps a

---
 rtl/mouse_cursor_tracker.sv | 175 +++++++++++++++++
 tb/tb_mouse_cursor_tracker.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mouse_cursor_tracker.sv
// Cursor/wheel/button tracker fed by decoded PS/2 mouse packets.
// Each trigger edge is captured in S1; S2 adds the scaled delta, clamps and registers all outputs.
module mouse_cursor_tracker #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int SHIFT      = 0,
  parameter int DBL_CYCLES = 12500000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        iTrig,
  input  logic        iL,
  input  logic        iR,
  input  logic        iM,
  input  logic        iXs,
  input  logic        iYs,
  input  logic [7:0]  iX,
  input  logic [7:0]  iY,
  input  logic        iZ,
  input  logic        iZs,
  output logic [10:0] oPosX,
  output logic [10:0] oPosY,
  output logic [7:0]  oWheel,
  output logic        oL,
  output logic        oR,
  output logic        oM,
  output logic        oLPress,
  output logic        oRPress,
  output logic        oMPress,
  output logic        oDblClick,
  output logic        oUpdate
);
  localparam int STAGES = 1;
  localparam int CW     = $clog2(DBL_CYCLES + 2);
  localparam logic signed [12:0] XMAX = 13'(H_RES - 1);
  localparam logic signed [12:0] YMAX = 13'(V_RES - 1);
  localparam logic [CW-1:0]      DBL  = CW'(DBL_CYCLES);

  typedef enum logic {IDLE, ARMED} state_t;

  logic              r_trig_d;
  logic [STAGES:0]   r_vld_pipe;
  logic [8:0]        r_dx, r_dy;
  logic [2:0]        r_btn;
  logic              r_z, r_zs;
  logic [10:0]       r_posx, r_posy;
  logic [7:0]        r_wheel;
  logic              r_l, r_r, r_m;
  logic              r_lpress, r_rpress, r_mpress;
  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              w_dbl;

  logic              w_edge;
  logic signed [12:0] w_dx_sh, w_dy_sh, w_nx, w_ny, w_cx, w_cy;

  assign w_edge = iTrig & ~r_trig_d;

  // Capture stage: a held trigger only produces one edge.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_trig_d      <= 1'b0;
      r_vld_pipe[0] <= 1'b0;
      r_dx          <= '0;
      r_dy          <= '0;
      r_btn         <= '0;
      r_z           <= 1'b0;
      r_zs          <= 1'b0;
    end else begin
      r_trig_d      <= iTrig;
      r_vld_pipe[0] <= w_edge;
      if (w_edge) begin
        r_dx  <= {iXs, iX};
        r_dy  <= {iYs, iY};
        r_btn <= {iL, iR, iM};
        r_z   <= iZ;
        r_zs  <= iZs;
      end
    end
  end

  assign w_dx_sh = {{4{r_dx[8]}}, r_dx} <<< SHIFT;
  assign w_dy_sh = {{4{r_dy[8]}}, r_dy} <<< SHIFT;
  // Screen Y grows downward while PS/2 +Y points up.
  assign w_nx    = $signed({2'b00, r_posx}) + w_dx_sh;
  assign w_ny    = $signed({2'b00, r_posy}) - w_dy_sh;

  always_comb begin
    w_cx = w_nx;
    w_cy = w_ny;
    if (w_nx < 0)         w_cx = '0;
    else if (w_nx > XMAX) w_cx = XMAX;
    if (w_ny < 0)         w_cy = '0;
    else if (w_ny > YMAX) w_cy = YMAX;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_vld_pipe[STAGES] <= 1'b0;
      r_posx   <= 11'(H_RES / 2);
      r_posy   <= 11'(V_RES / 2);
      r_wheel  <= '0;
      r_l      <= 1'b0;
      r_r      <= 1'b0;
      r_m      <= 1'b0;
      r_lpress <= 1'b0;
      r_rpress <= 1'b0;
      r_mpress <= 1'b0;
    end else begin
      r_vld_pipe[STAGES] <= r_vld_pipe[0];
      r_lpress <= r_vld_pipe[0] & r_btn[2] & ~r_l;
      r_rpress <= r_vld_pipe[0] & r_btn[1] & ~r_r;
      r_mpress <= r_vld_pipe[0] & r_btn[0] & ~r_m;
      if (r_vld_pipe[0]) begin
        r_posx <= w_cx[10:0];
        r_posy <= w_cy[10:0];
        r_l    <= r_btn[2];
        r_r    <= r_btn[1];
        r_m    <= r_btn[0];
        if (r_z) r_wheel <= r_zs ? r_wheel - 8'd1 : r_wheel + 8'd1;
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A press landing after the window has expired starts a fresh window.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dbl       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_lpress) begin
          w_state_nxt = ARMED;
          w_cnt_nxt   = '0;
        end
      end
      ARMED: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_lpress && r_cnt < DBL) begin
          w_dbl       = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_lpress) begin
          w_cnt_nxt   = '0;
        end else if (r_cnt >= DBL) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign oPosX     = r_posx;
  assign oPosY     = r_posy;
  assign oWheel    = r_wheel;
  assign oL        = r_l;
  assign oR        = r_r;
  assign oM        = r_m;
  assign oLPress   = r_lpress;
  assign oRPress   = r_rpress;
  assign oMPress   = r_mpress;
  assign oDblClick = w_dbl;
  assign oUpdate   = r_vld_pipe[STAGES];
endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Scoreboard bench: stimulus pushes hand-computed results, per-DUT monitors pop on oUpdate.
// dut0 uses SHIFT=0 / DBL_CYCLES=100, dut1 uses SHIFT=2.
module tb_mouse_cursor_tracker;
  typedef struct packed {
    logic L, R, M, xs;
    logic [7:0] x;
    logic ys;
    logic [7:0] y;
    logic z, zs;
  } pkt_t;

  typedef struct {
    int x, y, w;
    logic [6:0] b; // {L,R,M,lp,rp,mp,dbl}
  } exp_t;

  logic clk, rst;
  logic trig0, trig1;
  pkt_t pk0, pk1;

  logic [10:0] x0, y0, x1, y1;
  logic [7:0]  w0, w1;
  logic L0, R0, M0, lp0, rp0, mp0, dbl0, upd0;
  logic L1, R1, M1, lp1, rp1, mp1, dbl1, upd1;

  exp_t q0[$], q1[$];
  int n_chk = 0, n_fail = 0;

  mouse_cursor_tracker #(.H_RES(640), .V_RES(480), .SHIFT(0), .DBL_CYCLES(100)) dut0 (
    .CLOCK(clk), .RESET(rst), .iTrig(trig0), .iL(pk0.L), .iR(pk0.R), .iM(pk0.M),
    .iXs(pk0.xs), .iYs(pk0.ys), .iX(pk0.x), .iY(pk0.y), .iZ(pk0.z), .iZs(pk0.zs),
    .oPosX(x0), .oPosY(y0), .oWheel(w0), .oL(L0), .oR(R0), .oM(M0),
    .oLPress(lp0), .oRPress(rp0), .oMPress(mp0), .oDblClick(dbl0), .oUpdate(upd0));

  mouse_cursor_tracker #(.H_RES(640), .V_RES(480), .SHIFT(2), .DBL_CYCLES(100)) dut1 (
    .CLOCK(clk), .RESET(rst), .iTrig(trig1), .iL(pk1.L), .iR(pk1.R), .iM(pk1.M),
    .iXs(pk1.xs), .iYs(pk1.ys), .iX(pk1.x), .iY(pk1.y), .iZ(pk1.z), .iZs(pk1.zs),
    .oPosX(x1), .oPosY(y1), .oWheel(w1), .oL(L1), .oR(R1), .oM(M1),
    .oLPress(lp1), .oRPress(rp1), .oMPress(mp1), .oDblClick(dbl1), .oUpdate(upd1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic pkt_t P(input logic [2:0] btn, input logic [8:0] dx, input logic [8:0] dy,
                             input logic z, input logic zs);
    pkt_t p;
    p.L = btn[2]; p.R = btn[1]; p.M = btn[0];
    p.xs = dx[8]; p.x = dx[7:0];
    p.ys = dy[8]; p.y = dy[7:0];
    p.z = z; p.zs = zs;
    return p;
  endfunction

  function automatic exp_t E(input int x, input int y, input int w, input logic [6:0] b);
    exp_t e;
    e.x = x; e.y = y; e.w = w; e.b = b;
    return e;
  endfunction

  task automatic send(input int d, input pkt_t p, input exp_t e, input int hold, input int gap);
    @(posedge clk); #1;
    if (d == 0) begin q0.push_back(e); pk0 = p; trig0 = 1'b1; end
    else        begin q1.push_back(e); pk1 = p; trig1 = 1'b1; end
    repeat (hold) @(posedge clk);
    #1;
    if (d == 0) trig0 = 1'b0; else trig1 = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic compare(input int d, input exp_t got);
    exp_t e;
    if (d == 0 && q0.size() == 0) begin chk("dut0_unexpected_update", 1, 0); return; end
    if (d == 1 && q1.size() == 0) begin chk("dut1_unexpected_update", 1, 0); return; end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("dut%0d_posx", d),   got.x, e.x);
    chk($sformatf("dut%0d_posy", d),   got.y, e.y);
    chk($sformatf("dut%0d_wheel", d),  got.w, e.w);
    chk($sformatf("dut%0d_btns", d),   int'(got.b), int'(e.b));
  endtask

  always @(negedge clk) if (!rst) begin
    if (upd0) compare(0, E(int'(x0), int'(y0), int'(w0), {L0, R0, M0, lp0, rp0, mp0, dbl0}));
    else if (lp0 | rp0 | mp0 | dbl0) chk("dut0_stray_pulse", 1, 0);
  end

  always @(negedge clk) if (!rst) begin
    if (upd1) compare(1, E(int'(x1), int'(y1), int'(w1), {L1, R1, M1, lp1, rp1, mp1, dbl1}));
    else if (lp1 | rp1 | mp1 | dbl1) chk("dut1_stray_pulse", 1, 0);
  end

  task automatic chk_reset_state;
    chk("rst_posx0", int'(x0), 320);
    chk("rst_posy0", int'(y0), 240);
    chk("rst_wheel0", int'(w0), 0);
    chk("rst_outs0", int'({L0, R0, M0, lp0, rp0, mp0, dbl0, upd0}), 0);
    chk("rst_posx1", int'(x1), 320);
    chk("rst_posy1", int'(y1), 240);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trig0 = 1'b0; trig1 = 1'b0;
    pk0 = '0; pk1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state();

    // SHIFT=2 instance: +3 -> +12, and a clamped Y.
    send(1, P(3'b000, 9'h003, 9'h1FF, 0, 0), E(332, 244, 0, 7'b0), 1, 4);
    send(1, P(3'b000, 9'h1FD, 9'h064, 0, 0), E(320, 0,   0, 7'b0), 1, 4);

    // Motion and clamping
    send(0, P(3'b000, 9'h00A, 9'h005, 0, 0), E(330, 235, 0, 7'b0), 1, 4);
    send(0, P(3'b000, 9'h101, 9'h0FF, 0, 0), E(75,  0,   0, 7'b0), 1, 1);
    send(0, P(3'b000, 9'h1BA, 9'h101, 0, 0), E(5,   255, 0, 7'b0), 1, 1);
    send(0, P(3'b000, 9'h1EC, 9'h101, 0, 0), E(0,   479, 0, 7'b0), 1, 1);
    send(0, P(3'b000, 9'h0FF, 9'h000, 0, 0), E(255, 479, 0, 7'b0), 1, 1);
    send(0, P(3'b000, 9'h0FF, 9'h000, 0, 0), E(510, 479, 0, 7'b0), 1, 1);
    send(0, P(3'b000, 9'h078, 9'h000, 0, 0), E(630, 479, 0, 7'b0), 1, 1);
    send(0, P(3'b000, 9'h064, 9'h000, 0, 1), E(639, 479, 0, 7'b0), 1, 4);
    // Wheel wrap
    send(0, P(3'b000, 9'h000, 9'h000, 1, 1), E(639, 479, 255, 7'b0), 1, 4);
    send(0, P(3'b000, 9'h000, 9'h000, 1, 0), E(639, 479, 0,   7'b0), 1, 4);
    send(0, P(3'b000, 9'h000, 9'h000, 1, 1), E(639, 479, 255, 7'b0), 1, 4);
    // Buttons: press pulses, hold without repeat, release silent
    send(0, P(3'b011, 9'h000, 9'h000, 0, 0), E(639, 479, 255, 7'b011_011_0), 1, 4);
    send(0, P(3'b010, 9'h000, 9'h000, 0, 0), E(639, 479, 255, 7'b010_000_0), 1, 4);
    send(0, P(3'b001, 9'h000, 9'h000, 0, 0), E(639, 479, 255, 7'b001_001_0), 1, 4);
    // Trigger held 50 cycles: one update only
    send(0, P(3'b000, 9'h1FF, 9'h000, 0, 0), E(638, 479, 255, 7'b0), 50, 5);
    // Double click: presses 60 apart fire; third rapid press re-arms; 150 apart do not fire
    send(0, P(3'b100, 9'h000, 9'h000, 0, 0), E(638, 479, 255, 7'b100_100_0), 1, 29);
    send(0, P(3'b000, 9'h000, 9'h000, 0, 0), E(638, 479, 255, 7'b0),         1, 29);
    send(0, P(3'b100, 9'h000, 9'h000, 0, 0), E(638, 479, 255, 7'b100_100_1), 1, 9);
    send(0, P(3'b000, 9'h000, 9'h000, 0, 0), E(638, 479, 255, 7'b0),         1, 9);
    send(0, P(3'b100, 9'h000, 9'h000, 0, 0), E(638, 479, 255, 7'b100_100_0), 1, 74);
    send(0, P(3'b000, 9'h000, 9'h000, 0, 0), E(638, 479, 255, 7'b0),         1, 74);
    send(0, P(3'b100, 9'h000, 9'h000, 0, 0), E(638, 479, 255, 7'b100_100_0), 1, 9);
    // Reset while ARMED: the next press must not be a double click
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state();
    send(0, P(3'b100, 9'h000, 9'h000, 0, 0), E(320, 240, 0, 7'b100_100_0), 1, 9);

    repeat (10) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
